// File: rtl/baggage_drop_ctrl.sv
// Sequencing controller in front of the combinational baggage_drop datapath.
// Arms on request, debounces the four raw height sensors, presents them with the
// latched time limit, reads back the datapath verdict and runs the hatch.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for arm; outputs quiet, last sensors/t_lim held
// SAMPLE | collecting valid samples until STABLE_CNT identical in a row
// EVAL   | drop_en held for EVAL_CYCLES, then drop_activated is sampled
// OPEN   | hatch open for OPEN_CYCLES (abort cuts it short into COOL)
// COOL   | forced idle after the hatch closes
// FAULT  | timeout or too many HOLD verdicts; left only through abort
module baggage_drop_ctrl #(
    parameter int STABLE_CNT  = 4,
    parameter int TIMEOUT     = 64,
    parameter int EVAL_CYCLES = 2,
    parameter int OPEN_CYCLES = 16,
    parameter int COOL_CYCLES = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        abort,
    input  logic        sensor_valid,
    input  logic [31:0] raw_sensors,
    input  logic [15:0] t_lim_in,
    input  logic        drop_activated,
    output logic [7:0]  sensor1,
    output logic [7:0]  sensor2,
    output logic [7:0]  sensor3,
    output logic [7:0]  sensor4,
    output logic [15:0] t_lim,
    output logic        drop_en,
    output logic        door_open,
    output logic        busy,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_EVAL   = 3'd2,
        ST_OPEN   = 3'd3,
        ST_COOL   = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam int STAB_W = $clog2(STABLE_CNT + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 1);

    // One down-counter serves EVAL, OPEN and COOL since they never overlap.
    localparam int TMR_MAX1 = (EVAL_CYCLES > OPEN_CYCLES) ? EVAL_CYCLES : OPEN_CYCLES;
    localparam int TMR_MAX  = (TMR_MAX1 > COOL_CYCLES) ? TMR_MAX1 : COOL_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [STAB_W-1:0] STAB_TC  = STAB_W'(STABLE_CNT);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_SAT  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [RTY_W-1:0]  RTY_TC   = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0]  RTY_ONE  = RTY_W'(1);
    localparam logic [TMR_W-1:0]  EVAL_LD  = TMR_W'(EVAL_CYCLES - 1);
    localparam logic [TMR_W-1:0]  OPEN_LD  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  COOL_LD  = TMR_W'(COOL_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);

    state_e              state_q,     state_d;
    logic [STAB_W-1:0]   stab_cnt_q,  stab_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q,   tmo_cnt_d;
    logic [RTY_W-1:0]    retry_cnt_q, retry_cnt_d;
    logic [TMR_W-1:0]    tmr_q,       tmr_d;
    logic                first_q,     first_d;
    logic [31:0]         shadow_q,    shadow_d;
    logic [31:0]         sensors_q,   sensors_d;
    logic [15:0]         t_lim_q,     t_lim_d;
    logic                drop_en_q,   drop_en_d;
    logic                door_open_q, door_open_d;
    logic                busy_q,      busy_d;
    logic                fault_q,     fault_d;
    logic                stable_hit;

    // State, counters, capture registers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stab_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
            tmr_q       <= '0;
            first_q     <= 1'b0;
            shadow_q    <= '0;
            sensors_q   <= '0;
            t_lim_q     <= '0;
            drop_en_q   <= 1'b0;
            door_open_q <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            tmr_q       <= tmr_d;
            first_q     <= first_d;
            shadow_q    <= shadow_d;
            sensors_q   <= sensors_d;
            t_lim_q     <= t_lim_d;
            drop_en_q   <= drop_en_d;
            door_open_q <= door_open_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they change on the entering edge.
    always_comb begin
        state_d     = state_q;
        stab_cnt_d  = stab_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        tmr_d       = tmr_q;
        first_d     = first_q;
        shadow_d    = shadow_q;
        sensors_d   = sensors_q;
        t_lim_d     = t_lim_q;
        stable_hit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm && !abort) begin
                    state_d     = ST_SAMPLE;
                    t_lim_d     = t_lim_in;
                    stab_cnt_d  = '0;
                    tmo_cnt_d   = '0;
                    retry_cnt_d = '0;
                    first_d     = 1'b1;
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = (tmo_cnt_q == TMO_SAT) ? tmo_cnt_q : tmo_cnt_q + TMO_ONE;
                    if (sensor_valid) begin
                        first_d = 1'b0;
                        // The first sample after entry always restarts the run, even if it
                        // happens to match whatever the shadow held from a previous attempt.
                        if (!first_q && (raw_sensors == shadow_q)) begin
                            stab_cnt_d = (stab_cnt_q == STAB_TC) ? stab_cnt_q : stab_cnt_q + STAB_ONE;
                        end else begin
                            shadow_d   = raw_sensors;
                            stab_cnt_d = STAB_ONE;
                        end
                        stable_hit = (stab_cnt_d == STAB_TC);
                    end
                    // Stability is checked first so it wins a tie with the timeout.
                    if (stable_hit) begin
                        sensors_d = raw_sensors;
                        tmr_d     = EVAL_LD;
                        state_d   = ST_EVAL;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_d = ST_FAULT;
                    end
                end
            end

            ST_EVAL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    if (drop_activated) begin
                        tmr_d   = OPEN_LD;
                        state_d = ST_OPEN;
                    end else begin
                        retry_cnt_d = (retry_cnt_q == RTY_TC) ? retry_cnt_q : retry_cnt_q + RTY_ONE;
                        if (retry_cnt_d == RTY_TC) begin
                            state_d = ST_FAULT;
                        end else begin
                            stab_cnt_d = '0;
                            tmo_cnt_d  = '0;
                            first_d    = 1'b1;
                            state_d    = ST_SAMPLE;
                        end
                    end
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end

            ST_OPEN: begin
                // Abort still routes through COOL so the hatch gets its cooldown.
                if (abort || (tmr_q == '0)) begin
                    tmr_d   = COOL_LD;
                    state_d = ST_COOL;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end

            ST_COOL: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end

            ST_FAULT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        drop_en_d   = (state_d == ST_EVAL) || (state_d == ST_OPEN);
        door_open_d = (state_d == ST_OPEN);
        busy_d      = (state_d != ST_IDLE);
        fault_d     = (state_d == ST_FAULT);
    end

    assign sensor1   = sensors_q[7:0];
    assign sensor2   = sensors_q[15:8];
    assign sensor3   = sensors_q[23:16];
    assign sensor4   = sensors_q[31:24];
    assign t_lim     = t_lim_q;
    assign drop_en   = drop_en_q;
    assign door_open = door_open_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// Bench for baggage_drop_ctrl: a nominal-sequence vector table, hand-written
// corner sequences, then random stimulus against a behavioural model.
module tb_baggage_drop_ctrl;

    localparam int STABLE_CNT  = 4;
    localparam int TIMEOUT     = 64;
    localparam int EVAL_CYCLES = 2;
    localparam int OPEN_CYCLES = 16;
    localparam int COOL_CYCLES = 8;
    localparam int MAX_RETRY   = 3;

    localparam int P_IDLE = 0, P_SAMPLE = 1, P_EVAL = 2, P_OPEN = 3, P_COOL = 4, P_FAULT = 5;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        abort;
    logic        sensor_valid;
    logic [31:0] raw_sensors;
    logic [15:0] t_lim_in;
    logic        drop_activated;
    logic [7:0]  sensor1, sensor2, sensor3, sensor4;
    logic [15:0] t_lim;
    logic        drop_en, door_open, busy, fault;
    logic [2:0]  state;

    baggage_drop_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .arm            (arm),
        .abort          (abort),
        .sensor_valid   (sensor_valid),
        .raw_sensors    (raw_sensors),
        .t_lim_in       (t_lim_in),
        .drop_activated (drop_activated),
        .sensor1        (sensor1),
        .sensor2        (sensor2),
        .sensor3        (sensor3),
        .sensor4        (sensor4),
        .t_lim          (t_lim),
        .drop_en        (drop_en),
        .door_open      (door_open),
        .busy           (busy),
        .fault          (fault),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        de;
        logic        dopen;
        logic        bsy;
        logic        flt;
        logic [31:0] sens;
        logic [15:0] tlim;
    } outs_t;

    int checks = 0;
    int errors = 0;
    logic door_seen;

    function automatic outs_t dut_outs();
        outs_t o;
        o.st    = state;
        o.de    = drop_en;
        o.dopen = door_open;
        o.bsy   = busy;
        o.flt   = fault;
        o.sens  = {sensor4, sensor3, sensor2, sensor1};
        o.tlim  = t_lim;
        return o;
    endfunction

    task automatic check_out(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got st=%0d de=%b door=%b busy=%b fault=%b sens=%h tlim=%h, expected st=%0d de=%b door=%b busy=%b fault=%b sens=%h tlim=%h",
                     name, $time, got.st, got.de, got.dopen, got.bsy, got.flt, got.sens, got.tlim,
                     exp.st, exp.de, exp.dopen, exp.bsy, exp.flt, exp.sens, exp.tlim);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_phase;
    int          m_elapsed;
    int          m_retries;
    logic [31:0] m_hist[$];
    logic [31:0] m_sens;
    logic [15:0] m_tlim;

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_elapsed = 0;
        m_retries = 0;
        m_hist.delete();
        m_sens    = '0;
        m_tlim    = '0;
    endtask

    function automatic logic model_stable();
        int n;
        n = m_hist.size();
        if (n < STABLE_CNT) return 1'b0;
        for (int i = 1; i < STABLE_CNT; i++)
            if (m_hist[n-1-i] != m_hist[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic enter(input int ph);
        m_phase   = ph;
        m_elapsed = 0;
        if (ph == P_SAMPLE) m_hist.delete();
    endtask

    task automatic model_step();
        case (m_phase)
            P_IDLE: if (arm && !abort) begin
                m_tlim    = t_lim_in;
                m_retries = 0;
                enter(P_SAMPLE);
            end
            P_SAMPLE: if (abort) enter(P_IDLE);
            else begin
                m_elapsed++;
                if (sensor_valid) m_hist.push_back(raw_sensors);
                if (sensor_valid && model_stable()) begin
                    m_sens = raw_sensors;
                    enter(P_EVAL);
                end else if (m_elapsed == TIMEOUT) enter(P_FAULT);
            end
            P_EVAL: if (abort) enter(P_IDLE);
            else begin
                m_elapsed++;
                if (m_elapsed == EVAL_CYCLES) begin
                    if (drop_activated) enter(P_OPEN);
                    else begin
                        m_retries++;
                        enter(m_retries >= MAX_RETRY ? P_FAULT : P_SAMPLE);
                    end
                end
            end
            P_OPEN: if (abort) enter(P_COOL);
            else begin
                m_elapsed++;
                if (m_elapsed == OPEN_CYCLES) enter(P_COOL);
            end
            P_COOL: begin
                m_elapsed++;
                if (m_elapsed == COOL_CYCLES) enter(P_IDLE);
            end
            P_FAULT: if (abort) enter(P_IDLE);
            default: enter(P_IDLE);
        endcase
    endtask

    function automatic outs_t model_outs();
        outs_t o;
        o.st    = 3'(m_phase);
        o.de    = (m_phase == P_EVAL) || (m_phase == P_OPEN);
        o.dopen = (m_phase == P_OPEN);
        o.bsy   = (m_phase != P_IDLE);
        o.flt   = (m_phase == P_FAULT);
        o.sens  = m_sens;
        o.tlim  = m_tlim;
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (door_open) door_seen = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_in(input logic a, input logic ab, input logic v, input logic [31:0] r,
                          input logic [15:0] tl, input logic da);
        arm = a; abort = ab; sensor_valid = v; raw_sensors = r; t_lim_in = tl; drop_activated = da;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        door_seen = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        a;
        logic        v;
        int          n;
        outs_t       exp;
    } vec_t;

    localparam logic [31:0] RAW_NOM = 32'h20201E1F;
    localparam logic [15:0] TL_NOM  = 16'd500;

    function automatic outs_t mk(input int st, input logic de, input logic dopen, input logic bsy,
                                 input logic flt, input logic [31:0] s, input logic [15:0] tl);
        outs_t o;
        o.st = 3'(st); o.de = de; o.dopen = dopen; o.bsy = bsy; o.flt = flt; o.sens = s; o.tlim = tl;
        return o;
    endfunction

    vec_t vecs[9];
    logic [31:0] pool[4];
    logic [31:0] cur_raw;
    logic [31:0] va, vb, vc;

    initial begin
        vecs[0] = '{"arm_accept",   1'b1, 1'b1, 1,  mk(1, 0, 0, 1, 0, 32'h0,  TL_NOM)};
        vecs[1] = '{"sampling",     1'b0, 1'b1, 3,  mk(1, 0, 0, 1, 0, 32'h0,  TL_NOM)};
        vecs[2] = '{"eval_entry",   1'b0, 1'b1, 1,  mk(2, 1, 0, 1, 0, RAW_NOM, TL_NOM)};
        vecs[3] = '{"eval_hold",    1'b0, 1'b1, 1,  mk(2, 1, 0, 1, 0, RAW_NOM, TL_NOM)};
        vecs[4] = '{"open_entry",   1'b0, 1'b1, 1,  mk(3, 1, 1, 1, 0, RAW_NOM, TL_NOM)};
        vecs[5] = '{"open_last",    1'b0, 1'b1, 15, mk(3, 1, 1, 1, 0, RAW_NOM, TL_NOM)};
        vecs[6] = '{"cool_entry",   1'b0, 1'b1, 1,  mk(4, 0, 0, 1, 0, RAW_NOM, TL_NOM)};
        vecs[7] = '{"cool_last",    1'b0, 1'b1, 7,  mk(4, 0, 0, 1, 0, RAW_NOM, TL_NOM)};
        vecs[8] = '{"back_idle",    1'b0, 1'b1, 1,  mk(0, 0, 0, 0, 0, RAW_NOM, TL_NOM)};

        // reset state, checked while reset is still asserted
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        model_reset();
        door_seen = 1'b0;
        #12;
        check_out("reset", dut_outs(), mk(0, 0, 0, 0, 0, 32'h0, 16'h0));
        @(negedge clk);
        rst_n = 1'b1;

        // nominal drop sequence from the vector table
        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].a, 1'b0, vecs[i].v, RAW_NOM, TL_NOM, 1'b1);
            ticks(vecs[i].n);
            check_out(vecs[i].name, dut_outs(), vecs[i].exp);
        end

        // toggling s1 never stabilises: FAULT 64 cycles after arm
        apply_reset();
        set_in(1'b1, 1'b0, 1'b1, 32'h20201E10, TL_NOM, 1'b1);
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            raw_sensors = (k % 2 == 1) ? 32'h20201E10 : 32'h20201E11;
            tick();
            if (k == 63) check_val("timeout_pre", {29'h0, state}, 32'd1);
        end
        check_val("timeout_state", {29'h0, state}, 32'd5);
        check_val("timeout_fault", {31'h0, fault}, 32'd1);
        arm = 1'b1;
        tick();
        check_val("fault_arm_ignored", {29'h0, state}, 32'd5);
        arm = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("fault_abort", dut_outs(), mk(0, 0, 0, 0, 0, 32'h0, TL_NOM));

        // every verdict HOLD: two re-samples, then FAULT; hatch never opens
        apply_reset();
        set_in(1'b1, 1'b0, 1'b1, RAW_NOM, TL_NOM, 1'b0);
        tick();
        arm = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            ticks(4);
            check_val("retry_eval", {28'h0, state, drop_en}, {28'h0, 3'd2, 1'b1});
            ticks(2);
            if (v < 3) check_val("retry_resample", {28'h0, state, drop_en}, {28'h0, 3'd1, 1'b0});
            else       check_val("retry_fault", {28'h0, state, fault}, {28'h0, 3'd5, 1'b1});
        end
        check_val("retry_no_door", {31'h0, door_seen}, 32'd0);

        // abort in the 5th cycle of OPEN goes to COOL, then IDLE 8 cycles later
        apply_reset();
        set_in(1'b1, 1'b0, 1'b1, RAW_NOM, TL_NOM, 1'b1);
        tick();
        arm = 1'b0;
        ticks(6);
        check_val("abort_open_reached", {29'h0, state}, 32'd3);
        ticks(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("abort_open_cool", dut_outs(), mk(4, 0, 0, 1, 0, RAW_NOM, TL_NOM));
        ticks(7);
        check_val("abort_cool_hold", {29'h0, state}, 32'd4);
        tick();
        check_val("abort_cool_idle", {29'h0, state}, 32'd0);

        // async reset mid-OPEN clears outputs immediately; arm works after release
        apply_reset();
        set_in(1'b1, 1'b0, 1'b1, RAW_NOM, TL_NOM, 1'b1);
        tick();
        arm = 1'b0;
        ticks(8);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", dut_outs(), mk(0, 0, 0, 0, 0, 32'h0, 16'h0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_val("rearm_after_reset", {28'h0, state, busy}, {28'h0, 3'd1, 1'b1});

        // valid every other cycle: EVAL after the 4th valid sample (7th cycle)
        apply_reset();
        set_in(1'b1, 1'b0, 1'b0, RAW_NOM, TL_NOM, 1'b1);
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            sensor_valid = (k % 2 == 1);
            tick();
            if (k == 6) check_val("alt_valid_pre", {29'h0, state}, 32'd1);
        end
        check_val("alt_valid_eval", {29'h0, state}, 32'd2);

        // stability reached on the same edge as the timeout: EVAL wins
        apply_reset();
        va = 32'h11223344; vb = 32'h11223345; vc = 32'h0A0B0C0D;
        set_in(1'b1, 1'b0, 1'b1, va, TL_NOM, 1'b1);
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            raw_sensors = (k <= 60) ? ((k % 2 == 1) ? va : vb) : vc;
            tick();
            if (k == 63) check_val("tie_pre", {29'h0, state}, 32'd1);
        end
        check_out("tie_eval", dut_outs(), mk(2, 1, 0, 1, 0, vc, TL_NOM));

        // randomized traffic against the behavioural model
        apply_reset();
        pool[0] = RAW_NOM; pool[1] = 32'h1F1F1F1F; pool[2] = 32'h20201E1E; pool[3] = 32'h00FF00FF;
        cur_raw = pool[0];
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) cur_raw = pool[$urandom_range(0, 3)];
            set_in($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                   cur_raw, 16'($urandom), 1'($urandom_range(0, 1)));
            tick();
            check_out("random", dut_outs(), model_outs());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
